// File: rtl/rtc_pkg.sv
// rtc_pkg: shared types and calendar helpers for the real-time clock.
//   rtc_time_t      - packed BCD time/date: century, year, month, day,
//                     hour, min, sec (each a tens nibble then a ones nibble).
//   RST_*           - fixed part of the reset date/time (01-01 00:00:00).
//   bcd_inc()       - increment a two-digit BCD value (no wrap handling).
//   is_leap()       - Gregorian leap year from BCD century/year.
//   days_in_month() - BCD month length, 00 for an out-of-range month.
//   digits_ok()     - every nibble of a time value is a legal BCD digit.
package rtc_pkg;

    typedef struct packed {
        logic [7:0] century;
        logic [7:0] year;
        logic [7:0] month;
        logic [7:0] day;
        logic [7:0] hour;
        logic [7:0] min;
        logic [7:0] sec;
    } rtc_time_t;

    localparam logic [7:0] RST_MONTH = 8'h01;
    localparam logic [7:0] RST_DAY   = 8'h01;
    localparam logic [7:0] RST_HOUR  = 8'h00;
    localparam logic [7:0] RST_MIN   = 8'h00;
    localparam logic [7:0] RST_SEC   = 8'h00;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // 10 = 2 (mod 4), so a BCD byte mod 4 is (2*tens + ones) mod 4.
    function automatic logic [1:0] bcd_mod4(input logic [7:0] v);
        logic [1:0] r;
        r = {v[4], 1'b0} + v[1:0];
        return r;
    endfunction

    // Year 00 is a leap year only when the century is divisible by 4.
    function automatic logic is_leap(input logic [7:0] century, input logic [7:0] year);
        if (year == 8'h00)
            return bcd_mod4(century) == 2'd0;
        else
            return bcd_mod4(year) == 2'd0;
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] month,
                                                 input logic [7:0] year,
                                                 input logic [7:0] century);
        case (month)
            8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: return 8'h31;
            8'h04, 8'h06, 8'h09, 8'h11:                      return 8'h30;
            8'h02:   return is_leap(century, year) ? 8'h29 : 8'h28;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic digits_ok(input rtc_time_t t);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (t[i*4 +: 4] > 4'd9)
                ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// rtc_tick_gen: one-second prescaler counting 0..TICK_HZ-1.
//   clk   - system clock
//   reset - asynchronous active-low reset, count returns to 0
//   clear - synchronous clear to 0 (valid time load)
//   tc    - high while the count sits at TICK_HZ-1
module rtc_tick_gen #(
    parameter int TICK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tc
);

    localparam int CW = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_HZ - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clear || count == LAST)
            count <= '0;
        else
            count <= count + CW'(1);
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/rtc_calendar_param.sv
// rtc_calendar_param: BCD real-time clock/calendar with validated load,
// Gregorian leap years, hh:mm alarm and 12/24-hour display digits.
//   clk, reset          - system clock, asynchronous active-low reset
//   mode_24h            - display mode (1 = 24 h); affects display only
//   set_valid/set_ready - load handshake; set_time is the BCD value offered
//   set_err             - pulse: offered value was out of range
//   alarm_en, alarm_hm  - alarm enable and BCD hh:mm (24 h)
//   alarm_hit           - pulse when a second advance lands on hh:mm:00
//   sec_tick            - pulse once per second, aligned with the now update
//   now                 - current time/date, 24 h BCD
//   hour_10d, hour_1d   - display hour digits; am_pm - 1 = PM
module rtc_calendar_param
    import rtc_pkg::*;
#(
    parameter int         TICK_HZ     = 100_000_000,
    parameter logic [7:0] RST_CENTURY = 8'h20,
    parameter logic [7:0] RST_YEAR    = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode_24h,
    input  logic        set_valid,
    output logic        set_ready,
    input  logic [55:0] set_time,
    output logic        set_err,
    input  logic        alarm_en,
    input  logic [15:0] alarm_hm,
    output logic        alarm_hit,
    output logic        sec_tick,
    output logic [55:0] now,
    output logic [3:0]  hour_1d,
    output logic [3:0]  hour_10d,
    output logic        am_pm
);

    localparam rtc_time_t RST_TIME = '{century: RST_CENTURY, year: RST_YEAR,
                                       month: RST_MONTH, day: RST_DAY,
                                       hour: RST_HOUR, min: RST_MIN, sec: RST_SEC};

    rtc_time_t cur;
    rtc_time_t nxt;
    rtc_time_t ld;
    logic      tc;
    logic      xfer;
    logic      ld_valid;
    logic      load_ok;
    logic      alarm_match;
    logic [4:0] hour_bin;
    logic [4:0] hour_12;

    assign ld      = set_time;
    assign now     = cur;
    assign xfer    = set_valid && set_ready;
    assign load_ok = xfer && ld_valid;

    rtc_tick_gen #(.TICK_HZ(TICK_HZ)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (load_ok),
        .tc    (tc)
    );

    // Range check of the offered value. With legal digits, BCD bytes order
    // the same as their decimal values, so plain compares suffice.
    always_comb begin
        ld_valid = digits_ok(ld)
                && (ld.sec   <= 8'h59)
                && (ld.min   <= 8'h59)
                && (ld.hour  <= 8'h23)
                && (ld.month >= 8'h01) && (ld.month <= 8'h12)
                && (ld.day   >= 8'h01)
                && (ld.day   <= days_in_month(ld.month, ld.year, ld.century));
    end

    // Full one-second carry chain, resolved in a single cycle.
    always_comb begin
        nxt = cur;
        if (cur.sec == 8'h59) begin
            nxt.sec = 8'h00;
            if (cur.min == 8'h59) begin
                nxt.min = 8'h00;
                if (cur.hour == 8'h23) begin
                    nxt.hour = 8'h00;
                    if (cur.day >= days_in_month(cur.month, cur.year, cur.century)) begin
                        nxt.day = 8'h01;
                        if (cur.month == 8'h12) begin
                            nxt.month = 8'h01;
                            if (cur.year == 8'h99) begin
                                nxt.year    = 8'h00;
                                nxt.century = (cur.century == 8'h99) ? 8'h00 : bcd_inc(cur.century);
                            end else begin
                                nxt.year = bcd_inc(cur.year);
                            end
                        end else begin
                            nxt.month = bcd_inc(cur.month);
                        end
                    end else begin
                        nxt.day = bcd_inc(cur.day);
                    end
                end else begin
                    nxt.hour = bcd_inc(cur.hour);
                end
            end else begin
                nxt.min = bcd_inc(cur.min);
            end
        end else begin
            nxt.sec = bcd_inc(cur.sec);
        end
    end

    assign alarm_match = alarm_en
                      && (nxt.hour == alarm_hm[15:8])
                      && (nxt.min  == alarm_hm[7:0])
                      && (nxt.sec  == 8'h00);

    // A load on the terminal-count cycle wins; the advance for that second
    // is dropped, but sec_tick still fires so the second count stays honest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur       <= RST_TIME;
            set_ready <= 1'b0;
            sec_tick  <= 1'b0;
            set_err   <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            set_ready <= 1'b1;
            sec_tick  <= tc;
            set_err   <= xfer && !ld_valid;
            alarm_hit <= tc && !load_ok && alarm_match;
            if (load_ok)
                cur <= ld;
            else if (tc)
                cur <= nxt;
        end
    end

    // 12-hour conversion goes through binary: 00 -> 12, 13..23 -> 01..11.
    always_comb begin
        hour_bin = 5'(cur.hour[7:4]) * 5'd10 + 5'(cur.hour[3:0]);
        if (hour_bin == 5'd0)
            hour_12 = 5'd12;
        else if (hour_bin > 5'd12)
            hour_12 = hour_bin - 5'd12;
        else
            hour_12 = hour_bin;

        am_pm = (cur.hour >= 8'h12);
        if (mode_24h) begin
            hour_10d = cur.hour[7:4];
            hour_1d  = cur.hour[3:0];
        end else if (hour_12 >= 5'd10) begin
            hour_10d = 4'd1;
            hour_1d  = 4'(hour_12 - 5'd10);
        end else begin
            hour_10d = 4'd0;
            hour_1d  = hour_12[3:0];
        end
    end

endmodule

// File: tb/tb_rtc_calendar_param.sv
// tb_rtc_calendar_param: directed checks of rtc_calendar_param at TICK_HZ=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rtc_calendar_param;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mode_24h = 1'b0;
    logic        set_valid = 1'b0;
    logic [55:0] set_time = '0;
    logic        alarm_en = 1'b0;
    logic [15:0] alarm_hm = '0;
    logic        set_ready, set_err, alarm_hit, sec_tick, am_pm;
    logic [55:0] now;
    logic [3:0]  hour_1d, hour_10d;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    rtc_calendar_param #(.TICK_HZ(4), .RST_CENTURY(8'h20), .RST_YEAR(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode_24h  (mode_24h),
        .set_valid (set_valid),
        .set_ready (set_ready),
        .set_time  (set_time),
        .set_err   (set_err),
        .alarm_en  (alarm_en),
        .alarm_hm  (alarm_hm),
        .alarm_hit (alarm_hit),
        .sec_tick  (sec_tick),
        .now       (now),
        .hour_1d   (hour_1d),
        .hour_10d  (hour_10d),
        .am_pm     (am_pm)
    );

    function automatic logic [55:0] t(input logic [7:0] c, input logic [7:0] y,
                                      input logic [7:0] mo, input logic [7:0] d,
                                      input logic [7:0] h, input logic [7:0] mi,
                                      input logic [7:0] s);
        return {c, y, mo, d, h, mi, s};
    endfunction

    task automatic chk(input string tag, input logic [55:0] obs, input logic [55:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [55:0] v);
        set_valid = 1'b1;
        set_time  = v;
        @(negedge clk);
        set_valid = 1'b0;
    endtask

    task automatic roll(input string tag, input logic [55:0] ld, input logic [55:0] exp);
        load(ld);
        cyc(4);
        chk(tag, now, exp);
        chk({tag, "_tick"}, sec_tick, 1'b1);
    endtask

    initial begin
        // Held in reset
        cyc(2);
        chk("rst_now", now, t(8'h20, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00));
        chk("rst_ready", set_ready, 1'b0);
        chk("rst_tick", sec_tick, 1'b0);
        chk("rst_err", set_err, 1'b0);
        chk("rst_alarm", alarm_hit, 1'b0);
        chk("rst_h10", hour_10d, 4'd1);
        chk("rst_h1", hour_1d, 4'd2);
        chk("rst_ampm", am_pm, 1'b0);
        mode_24h = 1'b1;
        #1;
        chk("rst_h24", {hour_10d, hour_1d}, 8'h00);
        mode_24h = 1'b0;

        // Release: ready next edge, tick every 4 cycles
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("tick_%0d", i), sec_tick, (i % 4 == 0));
            if (i == 1) chk("ready_up", set_ready, 1'b1);
            if (i == 4) chk("now_1s", now, t(8'h20, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01));
        end
        chk("now_2s", now, t(8'h20, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02));

        // Year rollover, PM -> AM
        load(t(8'h20, 8'h23, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59));
        chk("ny_loaded", now, t(8'h20, 8'h23, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59));
        chk("ny_err", set_err, 1'b0);
        chk("ny_pm", am_pm, 1'b1);
        chk("ny_h12", {hour_10d, hour_1d}, 8'h11);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("ny_tick_%0d", i), sec_tick, (i == 4));
        end
        chk("ny_roll", now, t(8'h20, 8'h24, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00));
        chk("ny_am", am_pm, 1'b0);
        chk("ny_h12_mid", {hour_10d, hour_1d}, 8'h12);

        // February end in leap / non-leap / century years
        roll("feb_2024", t(8'h20, 8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59),
                         t(8'h20, 8'h24, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00));
        roll("feb_2100", t(8'h21, 8'h00, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59),
                         t(8'h21, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00));
        roll("feb_2000", t(8'h20, 8'h00, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59),
                         t(8'h20, 8'h00, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00));
        roll("feb_2023", t(8'h20, 8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59),
                         t(8'h20, 8'h23, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00));
        roll("feb29_2024", t(8'h20, 8'h24, 8'h02, 8'h29, 8'h23, 8'h59, 8'h59),
                           t(8'h20, 8'h24, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00));
        roll("cent_wrap", t(8'h99, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59),
                          t(8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00));

        // Rejected loads
        load(t(8'h20, 8'h22, 8'h06, 8'h15, 8'h10, 8'h20, 8'h30));
        chk("k_loaded", now, t(8'h20, 8'h22, 8'h06, 8'h15, 8'h10, 8'h20, 8'h30));
        load(t(8'h20, 8'h22, 8'h04, 8'h31, 8'h10, 8'h20, 8'h30));
        chk("apr31_err", set_err, 1'b1);
        chk("apr31_now", now, t(8'h20, 8'h22, 8'h06, 8'h15, 8'h10, 8'h20, 8'h30));
        load(t(8'h20, 8'h22, 8'h13, 8'h15, 8'h10, 8'h20, 8'h30));
        chk("mon13_err", set_err, 1'b1);
        chk("mon13_now", now, t(8'h20, 8'h22, 8'h06, 8'h15, 8'h10, 8'h20, 8'h30));
        cyc(1);
        chk("err_clear", set_err, 1'b0);
        cyc(1);
        chk("k_tick", sec_tick, 1'b1);
        chk("k_adv", now, t(8'h20, 8'h22, 8'h06, 8'h15, 8'h10, 8'h20, 8'h31));
        load(t(8'h20, 8'h22, 8'h06, 8'h15, 8'h10, 8'h20, 8'h3A));
        chk("secA_err", set_err, 1'b1);
        chk("secA_now", now, t(8'h20, 8'h22, 8'h06, 8'h15, 8'h10, 8'h20, 8'h31));
        cyc(3);
        chk("secA_phase", sec_tick, 1'b1);
        chk("secA_adv", now, t(8'h20, 8'h22, 8'h06, 8'h15, 8'h10, 8'h20, 8'h32));

        // Load on the terminal-count cycle
        load(t(8'h20, 8'h30, 8'h07, 8'h04, 8'h08, 8'h00, 8'h00));
        cyc(3);
        chk("tc_pre", sec_tick, 1'b0);
        load(t(8'h20, 8'h30, 8'h07, 8'h04, 8'h09, 8'h30, 8'h15));
        chk("tc_load_now", now, t(8'h20, 8'h30, 8'h07, 8'h04, 8'h09, 8'h30, 8'h15));
        chk("tc_load_tick", sec_tick, 1'b1);
        chk("tc_h12", {am_pm, hour_10d, hour_1d}, 9'h009);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("tc_next_%0d", i), sec_tick, (i == 4));
        end
        chk("tc_adv", now, t(8'h20, 8'h30, 8'h07, 8'h04, 8'h09, 8'h30, 8'h16));

        // Reset pulsed while a load is being offered
        set_valid = 1'b1;
        set_time  = t(8'h20, 8'h45, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("rl_now", now, t(8'h20, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00));
        chk("rl_ready", set_ready, 1'b0);
        chk("rl_tick", sec_tick, 1'b0);
        set_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rl_ready_up", set_ready, 1'b1);
        chk("rl_hold", now, t(8'h20, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00));

        // Alarm at 13:05
        alarm_hm = 16'h1305;
        alarm_en = 1'b1;
        load(t(8'h20, 8'h24, 8'h05, 8'h05, 8'h13, 8'h04, 8'h59));
        chk("al_load", alarm_hit, 1'b0);
        cyc(3);
        chk("al_pre", alarm_hit, 1'b0);
        cyc(1);
        chk("al_now", now, t(8'h20, 8'h24, 8'h05, 8'h05, 8'h13, 8'h05, 8'h00));
        chk("al_hit", alarm_hit, 1'b1);
        chk("al_tick", sec_tick, 1'b1);
        cyc(1);
        chk("al_once", alarm_hit, 1'b0);

        // Display of hour 13
        chk("d12", {am_pm, hour_10d, hour_1d}, 9'h101);
        mode_24h = 1'b1;
        #1;
        chk("d24", {am_pm, hour_10d, hour_1d}, 9'h113);
        mode_24h = 1'b0;

        // Loading the alarm time itself never fires
        load(t(8'h20, 8'h24, 8'h05, 8'h05, 8'h13, 8'h05, 8'h00));
        chk("noal_load", alarm_hit, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("noal_%0d", i), alarm_hit, 1'b0);
        end
        chk("noal_now", now, t(8'h20, 8'h24, 8'h05, 8'h05, 8'h13, 8'h05, 8'h01));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
